medidor_periodo: RTL and testbench

MEDIDOR_PERIODO -- requirements
Module: medidor_periodo

---
 rtl/medidor_periodo.sv | 93 +++++++++
 tb/tb_medidor_periodo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/medidor_periodo.sv
// Half-period meter: synchronizes an asynchronous square wave and reports the
// length (in clk cycles minus 1) and level of every interval between edges.
module medidor_periodo #(
  parameter int WIDTH       = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] lim_med,
  output logic             nivel_med,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_prev;
  logic                   edge_det;
  logic                   cnt_full;
  logic [WIDTH-1:0]       cnt;

  assign s_sync   = sync_q[SYNC_STAGES-1];
  assign edge_det = s_sync ^ s_prev;
  assign cnt_full = &cnt;

  // NOTE: every clocked register below uses non-blocking assignments so all
  // flops sample the pre-edge values of their neighbours, like real hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the synchronizer chain is reset too; otherwise the first edge
      // seen after reset would depend on whatever the flops powered up with.
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev <= s_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lim_med   <= '0;
      nivel_med <= 1'b0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        // Disabling discards the partial interval but keeps the last result.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (edge_det) state <= MEASURE;
          end
          MEASURE: begin
            if (edge_det) begin
              // An edge on the last count value still wins over timeout.
              lim_med   <= cnt;
              nivel_med <= s_prev;
              valid     <= 1'b1;
              timeout   <= 1'b0;
              cnt       <= '0;
            end else if (cnt_full) begin
              timeout <= 1'b1;
              state   <= IDLE;
              cnt     <= '0;
            end else begin
              cnt <= cnt + WIDTH'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_medidor_periodo.sv
// Randomized and directed bench for medidor_periodo, checked every cycle
// against a timestamp-based model of the interval rules.
module tb_medidor_periodo;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int MAXC = 8192;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         sig_in;
  logic [W-1:0] lim_med;
  logic         nivel_med;
  logic         valid;
  logic         timeout;

  medidor_periodo #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .sig_in   (sig_in),
    .lim_med  (lim_med),
    .nivel_med(nivel_med),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Model: sampled input history, reset timestamp, start of the open interval.
  bit  hist [0:MAXC-1];
  int  last_rst = 0;
  bit  active   = 1'b0;
  int  start    = 0;
  int  exp_lim  = 0;
  bit  exp_niv  = 1'b0;
  bit  exp_val  = 1'b0;
  bit  exp_to   = 1'b0;
  bit  cur      = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d cycle=%0d", tag, obs, expv, n);
    end
  endtask

  // Level the edge detector sees for an input sampled at edge k.
  function automatic bit lvl(input int k);
    if (k < 1 || k <= last_rst) return 1'b0;
    return hist[k];
  endfunction

  task automatic model_edge(input bit x, input bit en, input bit r);
    bit det;
    int d;
    hist[n] = x;
    exp_val = 1'b0;
    if (r) begin
      last_rst = n;
      active   = 1'b0;
      exp_lim  = 0;
      exp_niv  = 1'b0;
      exp_to   = 1'b0;
      return;
    end
    // A sampled level change reaches the detector S edges later.
    det = lvl(n - S) != lvl(n - S - 1);
    if (!en) begin
      active = 1'b0;
    end else if (!active) begin
      if (det) begin
        active = 1'b1;
        start  = n;
      end
    end else begin
      d = n - start - 1;
      if (det) begin
        exp_lim = d;
        exp_niv = lvl(n - S - 1);
        exp_val = 1'b1;
        exp_to  = 1'b0;
        start   = n;
      end else if (d == (1 << W) - 1) begin
        exp_to = 1'b1;
        active = 1'b0;
      end
    end
  endtask

  task automatic tick(input bit x, input bit en, input bit r);
    sig_in = x;
    enable = en;
    rst    = r;
    @(posedge clk);
    n++;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget: observed=%0d expected<%0d", n, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    model_edge(x, en, r);
    @(negedge clk);
    check("valid", valid, exp_val);
    check("timeout", timeout, exp_to);
    check("lim_med", lim_med, exp_lim);
    check("nivel_med", nivel_med, exp_niv);
  endtask

  task automatic hold(input int cycles, input bit en);
    for (int i = 0; i < cycles; i++) tick(cur, en, 1'b0);
  endtask

  task automatic seg(input int cycles, input bit en);
    cur = ~cur;
    hold(cycles, en);
  endtask

  initial begin
    sig_in = 1'b0;
    enable = 1'b0;
    rst    = 1'b1;

    // Reset state.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
    check("rst_lim", lim_med, 0);
    check("rst_valid", valid, 0);

    // Symmetric wave, toggling every 4 cycles: lim_med = 3.
    hold(3, 1'b1);
    for (int i = 0; i < 10; i++) seg(4, 1'b1);

    // Toggling every cycle: lim_med = 0, valid every cycle.
    for (int i = 0; i < 12; i++) seg(1, 1'b1);

    // Asymmetric 6 high / 3 low.
    cur = 1'b0;
    tick(cur, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      seg(6, 1'b1);
      seg(3, 1'b1);
    end

    // Input stops: timeout after 256 cycles, lim_med kept.
    seg(300, 1'b1);
    check("timeout_set", timeout, 1);
    seg(5, 1'b1);
    check("timeout_first_edge", timeout, 1);
    seg(5, 1'b1);
    check("timeout_second_edge", timeout, 0);
    check("lim_after_timeout", lim_med, 4);

    // 256-cycle interval: edge coincides with the last count value.
    seg(10, 1'b1);
    seg(256, 1'b1);
    seg(3, 1'b1);
    check("lim_full_scale", lim_med, 255);
    check("timeout_full_scale", timeout, 0);

    // Reset mid-interval with sig_in high, then disabled while toggling.
    cur = 1'b1;
    hold(3, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check("rst_mid_lim", lim_med, 0);
    for (int i = 0; i < 5; i++) seg(2, 1'b0);
    for (int i = 0; i < 4; i++) seg(4, 1'b1);
    hold(2, 1'b1);
    for (int i = 0; i < 3; i++) seg(7, 1'b1);

    // Random half-periods with occasional enable drops.
    for (int i = 0; i < 60; i++) begin
      int len;
      bit en;
      len = $urandom_range(1, 14);
      en  = ($urandom_range(0, 7) != 0);
      seg(len, en);
    end
    hold(6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
